// File: rtl/fwd_hazard_unit.sv
// Forwarding-select and load-use stall generation for the 5-stage pipeline.
// Tracks destination info through EX/MEM/WB and counts stall cycles.
module fwd_hazard_unit #(
  parameter int unsigned AW = 5,
  parameter int unsigned CW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] id_rs,
  input  logic [AW-1:0] id_rt,
  input  logic          id_rs_used,
  input  logic          id_rt_used,
  input  logic [AW-1:0] id_dest,
  input  logic          id_regwrite,
  input  logic          id_memread,
  input  logic          flush,
  output logic [1:0]    ex_fwd_a,
  output logic [1:0]    ex_fwd_b,
  output logic          stall,
  output logic [CW-1:0] stall_count
);

  logic [AW-1:0] ex_rs, ex_rt, ex_dest;
  logic          ex_rs_used, ex_rt_used, ex_regwrite, ex_memread;
  logic [AW-1:0] mem_dest;
  logic          mem_regwrite, mem_memread;
  logic [AW-1:0] wb_dest;
  logic          wb_regwrite;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_rs        <= '0;
      ex_rt        <= '0;
      ex_dest      <= '0;
      ex_rs_used   <= 1'b0;
      ex_rt_used   <= 1'b0;
      ex_regwrite  <= 1'b0;
      ex_memread   <= 1'b0;
      mem_dest     <= '0;
      mem_regwrite <= 1'b0;
      mem_memread  <= 1'b0;
      wb_dest      <= '0;
      wb_regwrite  <= 1'b0;
    end else begin
      mem_dest     <= ex_dest;
      mem_regwrite <= ex_regwrite;
      mem_memread  <= ex_memread;
      wb_dest      <= mem_dest;
      wb_regwrite  <= mem_regwrite;
      // Stall and flush both collapse to one bubble
      if (stall || flush) begin
        ex_rs       <= '0;
        ex_rt       <= '0;
        ex_dest     <= '0;
        ex_rs_used  <= 1'b0;
        ex_rt_used  <= 1'b0;
        ex_regwrite <= 1'b0;
        ex_memread  <= 1'b0;
      end else begin
        ex_rs       <= id_rs;
        ex_rt       <= id_rt;
        ex_dest     <= id_dest;
        ex_rs_used  <= id_rs_used;
        ex_rt_used  <= id_rt_used;
        ex_regwrite <= id_regwrite;
        ex_memread  <= id_memread;
      end
    end
  end

  always_comb begin
    stall = 1'b0;
    if (ex_memread && ex_regwrite && (ex_dest != '0)) begin
      stall = (id_rs_used && (id_rs == ex_dest)) ||
              (id_rt_used && (id_rt == ex_dest));
    end
  end

  // A load in MEM has no data yet; the stall keeps this case from arising
  function automatic logic mem_hit(input logic [AW-1:0] r);
    return mem_regwrite && !mem_memread && (mem_dest != '0) && (mem_dest == r);
  endfunction

  function automatic logic wb_hit(input logic [AW-1:0] r);
    return wb_regwrite && (wb_dest != '0) && (wb_dest == r);
  endfunction

  always_comb begin
    ex_fwd_a = 2'b00;
    ex_fwd_b = 2'b00;
    if (ex_rs_used) begin
      if (mem_hit(ex_rs))     ex_fwd_a = 2'b01;
      else if (wb_hit(ex_rs)) ex_fwd_a = 2'b10;
    end
    if (ex_rt_used) begin
      if (mem_hit(ex_rt))     ex_fwd_b = 2'b01;
      else if (wb_hit(ex_rt)) ex_fwd_b = 2'b10;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count <= '0;
    end else if (stall && (stall_count != '1)) begin
      stall_count <= stall_count + CW'(1);
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Randomized and directed checks of fwd_hazard_unit against an in-flight
// instruction model; a second CW=2 instance checks counter saturation.
module tb_fwd_hazard_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  id_rs, id_rt, id_dest;
  logic        id_rs_used, id_rt_used, id_regwrite, id_memread, flush;
  logic [1:0]  ex_fwd_a, ex_fwd_b, sat_fwd_a, sat_fwd_b;
  logic        stall, sat_stall;
  logic [15:0] stall_count;
  logic [1:0]  sat_count;

  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

  fwd_hazard_unit #(.AW(5), .CW(16)) u_dut (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
    .id_dest(id_dest), .id_regwrite(id_regwrite), .id_memread(id_memread), .flush(flush),
    .ex_fwd_a(ex_fwd_a), .ex_fwd_b(ex_fwd_b), .stall(stall), .stall_count(stall_count)
  );

  fwd_hazard_unit #(.AW(5), .CW(2)) u_sat (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
    .id_dest(id_dest), .id_regwrite(id_regwrite), .id_memread(id_memread), .flush(flush),
    .ex_fwd_a(sat_fwd_a), .ex_fwd_b(sat_fwd_b), .stall(sat_stall), .stall_count(sat_count)
  );

  typedef struct {
    logic [4:0] rs, rt, dest;
    logic       rsu, rtu, rw, mr;
  } ins_t;

  // Instructions in flight: 0 = EX, 1 = MEM, 2 = WB
  ins_t        pipe [3];
  int unsigned mcount;

  function automatic ins_t bubble();
    ins_t b;
    b.rs = 0; b.rt = 0; b.dest = 0;
    b.rsu = 0; b.rtu = 0; b.rw = 0; b.mr = 0;
    return b;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 3; i++) pipe[i] = bubble();
    mcount = 0;
  endfunction

  // Youngest older producer of a nonzero register supplies the operand
  function automatic logic [1:0] exp_fwd(input logic [4:0] src, input logic used);
    if (!used || src == 0) return 2'b00;
    for (int k = 1; k <= 2; k++)
      if (pipe[k].rw && pipe[k].dest == src) return 2'(k);
    return 2'b00;
  endfunction

  function automatic logic exp_stall();
    if (!(pipe[0].mr && pipe[0].rw && pipe[0].dest != 0)) return 1'b0;
    return (id_rs_used && id_rs == pipe[0].dest) || (id_rt_used && id_rt == pipe[0].dest);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one ID instruction for a cycle, check mid-cycle, advance model at the edge
  task automatic step(input logic [4:0] rs, input logic [4:0] rt, input logic rsu,
                      input logic rtu, input logic [4:0] dest, input logic rw,
                      input logic mr, input logic fl);
    logic es;
    ins_t cur;
    id_rs = rs; id_rt = rt; id_rs_used = rsu; id_rt_used = rtu;
    id_dest = dest; id_regwrite = rw; id_memread = mr; flush = fl;
    #4;
    es = exp_stall();
    chk("fwd_a", 32'(ex_fwd_a), 32'(exp_fwd(pipe[0].rs, pipe[0].rsu)));
    chk("fwd_b", 32'(ex_fwd_b), 32'(exp_fwd(pipe[0].rt, pipe[0].rtu)));
    chk("stall", 32'(stall), 32'(es));
    chk("stall_count", 32'(stall_count), mcount);
    chk("sat_count", 32'(sat_count), (mcount > 3) ? 32'd3 : mcount);
    chk("memload_fwd", 32'(pipe[1].mr && (ex_fwd_a == 2'b01 || ex_fwd_b == 2'b01)), 32'd0);
    @(posedge clk);
    cur.rs = rs; cur.rt = rt; cur.dest = dest;
    cur.rsu = rsu; cur.rtu = rtu; cur.rw = rw; cur.mr = mr;
    pipe[2] = pipe[1];
    pipe[1] = pipe[0];
    pipe[0] = (es || fl) ? bubble() : cur;
    if (es && mcount < 65535) mcount++;
    #1;
  endtask

  task automatic alu(input logic [4:0] d, input logic [4:0] a, input logic [4:0] b);
    step(a, b, 1'b1, 1'b1, d, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic lw(input logic [4:0] d, input logic [4:0] base);
    step(base, 5'd0, 1'b1, 1'b0, d, 1'b1, 1'b1, 1'b0);
  endtask

  // Asynchronous reset mid-cycle; outputs must clear before any edge
  task automatic do_reset();
    #2 reset = 1'b1;
    #1;
    chk("rst_fwd_a", 32'(ex_fwd_a), 32'd0);
    chk("rst_fwd_b", 32'(ex_fwd_b), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_count", 32'(stall_count), 32'd0);
    chk("rst_sat_count", 32'(sat_count), 32'd0);
    model_clear();
    id_rs = 0; id_rt = 0; id_rs_used = 0; id_rt_used = 0;
    id_dest = 0; id_regwrite = 0; id_memread = 0; flush = 0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] sat_tab [5];
    int unsigned c0;
    sat_tab[0] = 2'd1; sat_tab[1] = 2'd2; sat_tab[2] = 2'd3;
    sat_tab[3] = 2'd3; sat_tab[4] = 2'd3;
    reset = 1'b0;
    id_rs = 0; id_rt = 0; id_rs_used = 0; id_rt_used = 0;
    id_dest = 0; id_regwrite = 0; id_memread = 0; flush = 0;
    model_clear();
    #1;
    do_reset();

    // Back-to-back ALU dependency, then distance-2 and priority
    alu(5'd3, 5'd1, 5'd2);
    alu(5'd4, 5'd3, 5'd5);
    chk("alu_d1_a", 32'(ex_fwd_a), 32'd1);
    chk("alu_d1_b", 32'(ex_fwd_b), 32'd0);
    alu(5'd6, 5'd1, 5'd2);
    alu(5'd7, 5'd4, 5'd1);
    chk("alu_d2_a", 32'(ex_fwd_a), 32'd2);
    alu(5'd9, 5'd1, 5'd2);
    alu(5'd9, 5'd1, 5'd2);
    alu(5'd10, 5'd9, 5'd9);
    chk("prio_a", 32'(ex_fwd_a), 32'd1);
    chk("prio_b", 32'(ex_fwd_b), 32'd1);

    // Load-use: one stall, then WB forwarding on both operands
    c0 = stall_count;
    lw(5'd8, 5'd1);
    step(5'd8, 5'd8, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
    chk("lu_stall_drop", 32'(stall), 32'd0);
    chk("lu_count", 32'(stall_count), c0 + 1);
    step(5'd8, 5'd8, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
    chk("lu_fwd_a", 32'(ex_fwd_a), 32'd2);
    chk("lu_fwd_b", 32'(ex_fwd_b), 32'd2);

    // r0 destination never forwards or stalls
    lw(5'd0, 5'd1);
    step(5'd0, 5'd0, 1'b1, 1'b1, 5'd11, 1'b1, 1'b0, 1'b0);
    chk("r0_fwd_a", 32'(ex_fwd_a), 32'd0);
    chk("r0_fwd_b", 32'(ex_fwd_b), 32'd0);

    // Flush during the stall cycle: single bubble
    lw(5'd8, 5'd1);
    step(5'd8, 5'd2, 1'b1, 1'b1, 5'd12, 1'b1, 1'b0, 1'b1);
    chk("fl_stall_drop", 32'(stall), 32'd0);
    step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);

    // Mid-stream reset with a pending load in EX
    lw(5'd8, 5'd1);
    id_rs = 5'd8; id_rs_used = 1'b1; id_regwrite = 1'b1; id_dest = 5'd13;
    #1;
    chk("pre_rst_stall", 32'(stall), 32'd1);
    do_reset();

    // Saturation of the 2-bit counter over five load-use pairs
    for (int i = 0; i < 5; i++) begin
      lw(5'd8, 5'd0);
      step(5'd8, 5'd0, 1'b1, 1'b0, 5'd14, 1'b1, 1'b0, 1'b0);
      chk("sat_seq", 32'(sat_count), 32'(sat_tab[i]));
      chk("cnt_seq", 32'(stall_count), 32'(i + 1));
    end

    // Randomized traffic over a small register set to provoke hazards
    for (int n = 0; n < 500; n++) begin
      logic rw_r;
      rw_r = ($urandom % 4) != 0;
      step(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           ($urandom % 4) != 0, ($urandom % 2) != 0,
           5'($urandom_range(0, 3)), rw_r,
           rw_r && (($urandom % 3) == 0), ($urandom % 8) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
